// File: rtl/alu_arbiter_2ch_pkg.sv
// Shared definitions for the two-channel ALU scheduler: op codes, FSM encoding
// and the default datapath width.
package alu_ctrl_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB_AB = 2'b01,
    OP_SUB_BA = 2'b10,
    OP_MUL    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_EXEC  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_arbiter_2ch_if.sv
// Bundle of the two requester channels and the external ALU bus.
// slave = the scheduler, master = requesters plus the ALU.
interface alu_arbiter_2ch_if #(parameter int DW = 8);

  logic          req0_valid, req0_ready;
  logic [1:0]    req0_op;
  logic [DW-1:0] req0_a, req0_b;

  logic          req1_valid, req1_ready;
  logic [1:0]    req1_op;
  logic [DW-1:0] req1_a, req1_b;

  logic          rsp0_valid, rsp0_ready;
  logic          rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_data;

  logic [1:0]    alu_sel;
  logic          alu_oe;
  logic [DW-1:0] alu_a, alu_b;
  logic [DW-1:0] alu_result;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready,
    output alu_sel, alu_oe, alu_a, alu_b,
    input  alu_result
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready,
    input  alu_sel, alu_oe, alu_a, alu_b,
    output alu_result
  );

endinterface

// File: rtl/alu_arbiter_2ch_rr.sv
// Two-way round-robin grant. Grant is combinational from the valids; the
// last-granted pointer advances only on an accept pulse.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic last_grant;

  // On contention the channel that did not win last time goes first.
  always_comb begin
    grant = valid;
    if (valid[0] && valid[1])
      grant = last_grant ? 2'b01 : 2'b10;
  end

  assign grant_id = grant[1];

  // Reset to 1 so channel 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 1'b1;
    else if (accept)
      last_grant <= grant_id;
  end

endmodule

// File: rtl/alu_arbiter_2ch.sv
// Shares one external 8-bit ALU between two requesters: arbitrate, present
// operands, enable the ALU for one cycle, capture and hand back the result.
module alu_arbiter_2ch
  import alu_ctrl_pkg::*;
#(
  parameter int DW = alu_ctrl_pkg::DW
) (
  input  logic                clk,
  input  logic                rst,
  alu_arbiter_2ch_if.slave    io,
  output logic                busy,
  output logic [7:0]          done_cnt
);

  state_e        state_q, state_d;
  op_e           op_q;
  logic [DW-1:0] a_q, b_q, rsp_data_q;
  logic          ch_q;
  logic [7:0]    done_q;

  logic [1:0]    grant;
  logic          grant_id;
  logic          accept;
  logic          rsp_fire;

  rr_arbiter_2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid    ({io.req1_valid, io.req0_valid}),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_ADD;
      a_q        <= '0;
      b_q        <= '0;
      ch_q       <= 1'b0;
      rsp_data_q <= '0;
      done_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_q <= grant_id;
        op_q <= op_e'(grant_id ? io.req1_op : io.req0_op);
        a_q  <= grant_id ? io.req1_a : io.req0_a;
        b_q  <= grant_id ? io.req1_b : io.req0_b;
      end
      // The ALU only drives its result while enabled, i.e. during EXEC.
      if (state_q == ST_EXEC)
        rsp_data_q <= io.alu_result;
      if (rsp_fire)
        done_q <= done_q + 8'd1;
    end
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    rsp_fire      = 1'b0;
    io.req0_ready = 1'b0;
    io.req1_ready = 1'b0;
    io.rsp0_valid = 1'b0;
    io.rsp1_valid = 1'b0;
    io.alu_oe     = 1'b0;
    io.alu_sel    = '0;
    io.alu_a      = '0;
    io.alu_b      = '0;
    unique case (state_q)
      ST_IDLE: begin
        io.req0_ready = grant[0];
        io.req1_ready = grant[1];
        accept        = |grant;
        if (accept)
          state_d = ST_SETUP;
      end
      // Operands settle one cycle before the ALU is allowed onto the bus.
      ST_SETUP: begin
        io.alu_sel = op_q;
        io.alu_a   = a_q;
        io.alu_b   = b_q;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        io.alu_sel = op_q;
        io.alu_a   = a_q;
        io.alu_b   = b_q;
        io.alu_oe  = 1'b1;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        io.rsp0_valid = ~ch_q;
        io.rsp1_valid = ch_q;
        rsp_fire      = ch_q ? io.rsp1_ready : io.rsp0_ready;
        if (rsp_fire)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.rsp_data = rsp_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign done_cnt    = done_q;

endmodule

// File: tb/tb_alu_arbiter_2ch.sv
// Bench for alu_arbiter_2ch: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration, arithmetic and counting.
module tb_alu_arbiter_2ch;
  import alu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] done_cnt;

  alu_arbiter_2ch_if #(.DW(8)) io ();

  alu_arbiter_2ch #(.DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .io       (io),
    .busy     (busy),
    .done_cnt (done_cnt)
  );

  always #5 clk = ~clk;

  // External ALU; an undriven bus reads as 0 in this two-state model.
  always_comb begin
    io.alu_result = '0;
    if (io.alu_oe) begin
      case (op_e'(io.alu_sel))
        OP_ADD:    io.alu_result = io.alu_a + io.alu_b;
        OP_SUB_AB: io.alu_result = io.alu_a - io.alu_b;
        OP_SUB_BA: io.alu_result = io.alu_b - io.alu_a;
        default:   io.alu_result = io.alu_a * io.alu_b;
      endcase
    end
  end

  int         tests = 0;
  int         fails = 0;
  logic       pend_v  [2];
  logic [1:0] pend_op [2];
  logic [7:0] pend_a  [2];
  logic [7:0] pend_b  [2];
  int         last_ch;
  int         n_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      2'd0:    r = int'(a) + int'(b);
      2'd1:    r = int'(a) - int'(b);
      2'd2:    r = int'(b) - int'(a);
      default: r = int'(a) * int'(b);
    endcase
    return 8'(r);
  endfunction

  function automatic int winner();
    if (pend_v[0] && pend_v[1]) return 1 - last_ch;
    return pend_v[1] ? 1 : 0;
  endfunction

  task automatic drive_req();
    io.req0_valid = pend_v[0];  io.req0_op = pend_op[0];
    io.req0_a     = pend_a[0];  io.req0_b  = pend_b[0];
    io.req1_valid = pend_v[1];  io.req1_op = pend_op[1];
    io.req1_a     = pend_a[1];  io.req1_b  = pend_b[1];
  endtask

  task automatic issue(input int ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    pend_v[ch] = 1'b1; pend_op[ch] = op; pend_a[ch] = a; pend_b[ch] = b;
    drive_req();
  endtask

  // One full transaction from IDLE back to IDLE, holding off rsp_ready for
  // 'delay' cycles while the other channel's rsp_ready is raised.
  task automatic serve(input int delay, output logic [7:0] got);
    int w;
    logic [7:0] exp_r;
    w     = winner();
    exp_r = ref_res(pend_op[w], pend_a[w], pend_b[w]);
    got   = '0;
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("grant", 32'({io.req1_ready, io.req0_ready}), 32'(1 << w));
    @(negedge clk);
    pend_v[w] = 1'b0; last_ch = w; drive_req();
    #1;
    chk("setup_busy", 32'(busy), 1);
    chk("setup_oe", 32'(io.alu_oe), 0);
    chk("setup_sel", 32'(io.alu_sel), 32'(pend_op[w]));
    chk("setup_a", 32'(io.alu_a), 32'(pend_a[w]));
    chk("setup_b", 32'(io.alu_b), 32'(pend_b[w]));
    chk("setup_ready", 32'({io.req1_ready, io.req0_ready}), 0);
    @(negedge clk); #1;
    chk("exec_oe", 32'(io.alu_oe), 1);
    chk("exec_sel", 32'(io.alu_sel), 32'(pend_op[w]));
    chk("exec_a", 32'(io.alu_a), 32'(pend_a[w]));
    chk("exec_b", 32'(io.alu_b), 32'(pend_b[w]));
    @(negedge clk);
    if (w == 0) io.rsp1_ready = 1'b1; else io.rsp0_ready = 1'b1;
    #1;
    for (int i = 0; i <= delay; i++) begin
      chk("rsp_valid", 32'({io.rsp1_valid, io.rsp0_valid}), 32'(1 << w));
      chk("rsp_data", 32'(io.rsp_data), 32'(exp_r));
      chk("rsp_oe", 32'(io.alu_oe), 0);
      chk("rsp_busy", 32'(busy), 1);
      chk("rsp_req_blocked", 32'({io.req1_ready, io.req0_ready}), 0);
      chk("rsp_cnt_hold", 32'(done_cnt), 32'(n_done % 256));
      got = io.rsp_data;
      if (i == delay) begin
        if (w == 0) io.rsp0_ready = 1'b1; else io.rsp1_ready = 1'b1;
      end
      @(negedge clk); #1;
    end
    io.rsp0_ready = 1'b0; io.rsp1_ready = 1'b0;
    n_done++;
    chk("done_cnt", 32'(done_cnt), 32'(n_done % 256));
    chk("post_rsp_valid", 32'({io.rsp1_valid, io.rsp0_valid}), 0);
    chk("post_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] got;
    int w;
    int pat;

    last_ch = 1; n_done = 0;
    for (int c = 0; c < 2; c++) begin
      pend_v[c] = 1'b0; pend_op[c] = '0; pend_a[c] = '0; pend_b[c] = '0;
    end
    drive_req();
    io.rsp0_ready = 1'b0; io.rsp1_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_rsp_valid", 32'({io.rsp1_valid, io.rsp0_valid}), 0);
    chk("rst_req_ready", 32'({io.req1_ready, io.req0_ready}), 0);
    chk("rst_alu_oe", 32'(io.alu_oe), 0);
    chk("rst_alu_sel", 32'(io.alu_sel), 0);
    chk("rst_alu_a", 32'(io.alu_a), 0);
    chk("rst_alu_b", 32'(io.alu_b), 0);
    chk("rst_rsp_data", 32'(io.rsp_data), 0);

    // Contention straight out of reset: ch0, ch1, then again ch0, ch1.
    issue(0, OP_ADD, 8'd1, 8'd1);
    issue(1, OP_ADD, 8'd2, 8'd2);
    serve(0, got); chk("cont_first_ch0", 32'(got), 2);
    serve(0, got); chk("cont_then_ch1", 32'(got), 4);
    issue(0, OP_ADD, 8'd1, 8'd1);
    issue(1, OP_ADD, 8'd2, 8'd2);
    serve(0, got); chk("cont2_ch0", 32'(got), 2);
    serve(0, got); chk("cont2_ch1", 32'(got), 4);

    // Backpressure on ch0 while ch1 waits.
    issue(0, OP_SUB_AB, 8'd30, 8'd12);
    issue(1, OP_MUL, 8'd3, 8'd5);
    serve(5, got); chk("bp_ch0", 32'(got), 18);
    serve(0, got); chk("bp_ch1", 32'(got), 15);

    issue(0, OP_ADD, 8'd200, 8'd100);   serve(0, got); chk("add_wrap", 32'(got), 44);
    issue(1, OP_SUB_AB, 8'd5, 8'd10);   serve(0, got); chk("sub_ab", 32'(got), 251);
    issue(1, OP_SUB_BA, 8'd5, 8'd10);   serve(0, got); chk("sub_ba", 32'(got), 5);
    issue(1, OP_MUL, 8'd20, 8'd13);     serve(0, got); chk("mul_low", 32'(got), 4);

    while (n_done < 256) begin
      pat = $urandom_range(0, 2);
      for (int c = 0; c < 2; c++)
        if (!pend_v[c] && (pat == 2 || pat == c))
          issue(c, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      serve($urandom_range(0, 2), got);
    end
    chk("done_cnt_wrap", 32'(done_cnt), 0);

    // Reset while the ALU is enabled: everything drops, nothing completes.
    if (!pend_v[0] && !pend_v[1]) issue(0, OP_SUB_BA, 8'd9, 8'd4);
    w = winner();
    #1;
    chk("rx_grant", 32'({io.req1_ready, io.req0_ready}), 32'(1 << w));
    @(negedge clk);
    pend_v[w] = 1'b0; drive_req();
    @(negedge clk); #1;
    chk("rx_exec_oe", 32'(io.alu_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 2; c++) pend_v[c] = 1'b0;
    drive_req();
    last_ch = 1;
    #1;
    chk("rx_busy", 32'(busy), 0);
    chk("rx_alu_oe", 32'(io.alu_oe), 0);
    chk("rx_alu_sel", 32'(io.alu_sel), 0);
    chk("rx_alu_a", 32'(io.alu_a), 0);
    chk("rx_alu_b", 32'(io.alu_b), 0);
    chk("rx_rsp_data", 32'(io.rsp_data), 0);
    chk("rx_done_cnt", 32'(done_cnt), 0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("rx_no_rsp", 32'({io.rsp1_valid, io.rsp0_valid}), 0);
      chk("rx_idle", 32'(busy), 0);
    end
    issue(1, OP_MUL, 8'd7, 8'd9);
    serve(1, got); chk("rx_reissue", 32'(got), 63);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_2ch.md
# alu_arbiter_2ch

Two-channel round-robin scheduler that shares one 4-operation 8-bit ALU (add, a-b, b-a, low-byte multiply, tri-state output enable) between two requesters. It accepts one operation at a time via a valid/ready handshake and sequences the ALU's select, operands and output enable. It captures the ALU result into a register and returns it to the requesting channel on a held response handshake. The block sits between the ALU and the two masters that issue arithmetic work.

## Interface
- `DW`, 8, operand/result width; fixed to the ALU width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  channel request valid.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  2  operation code.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DW  operands.
- `rsp0_valid` / `rsp1_valid`  out  1  result available for channel.
- `rsp0_ready` / `rsp1_ready`  in  1  channel consumes result.
- `rsp_data`  out  DW  captured result, shared by both channels.
- `alu_sel`  out  2  ALU select.
- `alu_oe`  out  1  ALU output enable.
- `alu_a`, `alu_b`  out  DW  ALU operands.
- `alu_result`  in  DW  ALU result; high-Z when `alu_oe` = 0.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done_cnt`  out  8  completed-operation counter.

## Operation
- Op codes: ADD=00 (a+b), SUB_AB=01 (a-b), SUB_BA=10 (b-a), MUL=11 (low DW bits of a*b).
- All results are modulo 2^DW. No carry, borrow or overflow flags.
- FSM states: IDLE → SETUP → EXEC → RESP → IDLE.
- IDLE:
  - `reqN_ready` is combinational: high only for the arbitration winner while in IDLE.
  - On a `valid && ready` edge: latch op, a, b and the channel ID, update `last_grant`, go to SETUP.
- Arbitration:
  - If exactly one request is valid, that channel wins.
  - If both are valid, the winner is the channel ≠ `last_grant`.
  - `last_grant` resets to 1, so channel 0 wins the first contention.
- SETUP: drive `alu_sel`, `alu_a`, `alu_b` from the latches with `alu_oe` = 0. This gives the ALU stable operands before it is enabled.
- EXEC: `alu_oe` = 1, same operands. At the end of EXEC, register `alu_result` into `rsp_data` and go to RESP.
- RESP:
  - `rspN_valid` = 1 for the latched channel only. `rsp_data` is held stable.
  - On the `rspN_ready` edge: go to IDLE and increment `done_cnt` (wraps 255 → 0).
  - `rsp_ready` of the non-granted channel is ignored.
- Requests arriving outside IDLE are not accepted. `reqN_valid` must be held by the master until ready.
- `alu_oe` is 0 in every state except EXEC, so `alu_result` is sampled only while driven.
- Reset (any state, including mid-operation): go to IDLE.
  - The in-flight operation and any pending response are discarded. The requester must reissue.
  - Reset values: all outputs 0, operand/op/channel latches 0, `last_grant` = 1, `done_cnt` = 0.

## Timing
- Cycle T: IDLE with a winner → `reqN_ready` = 1, accepted at the T edge.
- T+1 SETUP, T+2 EXEC (result captured at the T+2 edge), T+3 RESP with `rspN_valid` = 1.
- Request-to-response latency: 3 cycles.
- Minimum occupancy: 4 cycles per operation (IDLE, SETUP, EXEC, RESP) with `rsp_ready` held high.
- RESP lasts until `rsp_ready`; there is no timeout.
- Back-to-back ops with contention alternate 0, 1, 0, 1…
- Simultaneous `rst` and any handshake: reset wins; no counter increment.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - op code constants `OP_ADD`, `OP_SUB_AB`, `OP_SUB_BA`, `OP_MUL`;
  - FSM state encoding `ST_IDLE`, `ST_SETUP`, `ST_EXEC`, `ST_RESP`;
  - `DW` default.
- One sub-module, `rr_arbiter_2`, is natural. It is combinational grant from two valids plus `last_grant`, with the pointer register kept inside it and updated on an accept pulse.
- The ALU is instantiated outside this block (at top level) and connected through the `alu_*` ports.

## Test plan
- ch0 ADD a=200, b=100, `rsp0_ready` = 1 → `req0_ready` at T, `rsp0_valid` at T+3, `rsp_data` = 44, `done_cnt` = 1.
- ch1 SUB_AB a=5, b=10 → 251. SUB_BA a=5, b=10 → 5. MUL a=20, b=13 → 4. Check `alu_oe` = 1 only in EXEC.
- Both channels valid from reset with ops ADD 1+1 and ADD 2+2:
  - ch0 is granted first (result 2), then ch1 (result 4);
  - a further simultaneous pair is granted ch0 then ch1 again.
- Response backpressure: hold `rsp0_ready` = 0 for 5 cycles after `rsp0_valid`.
  - `rsp_data` stays stable and the state stays in RESP.
  - `req1` stays unaccepted throughout; `done_cnt` does not change.
- Assert `rst` during EXEC:
  - next cycle IDLE, all outputs 0, no response, `done_cnt` unchanged;
  - a reissued request completes normally.
- 256 completed operations → `done_cnt` wraps to 0.
